regfile_mp_scoreboard: RTL and testbench

- Parametrised successor to the single-write, two-read register file.
- Provides NRD read ports and NWR write ports, with optional same-cycle write-to-read bypass.
- Keeps a per-register pending (scoreboard) bit for hazard detection.
- Includes a sequenced bulk-clear engine; sits in the decode stage of the pipelined CPU.

---
 rtl/regfile_mp_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-ported register file with a per-register pending scoreboard and a
// sequenced bulk-clear engine. Register 0 is hard-wired to zero and never pending.
module regfile_mp_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_sel,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                         state, state_next;
    logic   [AW-1:0]                idx;
    logic                           clr_done_next;
    logic   [NREGS-1:0][DATA_W-1:0] regs;
    logic   [NREGS-1:0]             pending;

    always_comb begin
        state_next    = state;
        clr_done_next = 1'b0;
        case (state)
            IDLE:  if (clr_req) state_next = CLEAR;
            CLEAR: if (idx == LAST) begin
                state_next    = IDLE;
                clr_done_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            idx      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_next;
            clr_done <= clr_done_next;
            if (state == IDLE) idx <= AW'(1);
            else               idx <= idx + AW'(1);
        end
    end

    assign clr_busy = (state == CLEAR);

    // Writers are applied in ascending index order so the highest-index port
    // wins a conflict; the issue is applied last so a new producer outranks
    // a same-cycle write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            regs    <= '0;
            pending <= '0;
        end else if (state == CLEAR) begin
            regs[idx]    <= '0;
            pending[idx] <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wen[w] && wsel[w*AW +: AW] != '0) begin
                    regs[wsel[w*AW +: AW]]    <= wdat[w*DATA_W +: DATA_W];
                    pending[wsel[w*AW +: AW]] <= 1'b0;
                end
            end
            if (issue_en && issue_sel != '0) pending[issue_sel] <= 1'b1;
        end
    end

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            rdat[p*DATA_W +: DATA_W] = regs[rsel[p*AW +: AW]];
            rbusy[p]                 = pending[rsel[p*AW +: AW]];
            if (BYPASS != 0 && state == IDLE && rsel[p*AW +: AW] != '0) begin
                for (int unsigned w = 0; w < NWR; w++) begin
                    if (wen[w] && wsel[w*AW +: AW] == rsel[p*AW +: AW]) begin
                        rdat[p*DATA_W +: DATA_W] = wdat[w*DATA_W +: DATA_W];
                        rbusy[p]                 = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench: default-parameter instance for ports/scoreboard/clear,
// plus a 64-bit, 4-read, 1-write, no-bypass instance.
module tb_regfile_mp_scoreboard;

    logic        clk;
    logic        n_rst;

    logic [9:0]  rsel;
    logic [63:0] rdat;
    logic [1:0]  rbusy;
    logic [1:0]  wen;
    logic [9:0]  wsel;
    logic [63:0] wdat;
    logic        issue_en;
    logic [4:0]  issue_sel;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    logic [19:0]  rsel_b;
    logic [255:0] rdat_b;
    logic [3:0]   rbusy_b;
    logic [0:0]   wen_b;
    logic [4:0]   wsel_b;
    logic [63:0]  wdat_b;
    logic         issue_en_b;
    logic [4:0]   issue_sel_b;
    logic         clr_req_b;
    logic         clr_busy_b;
    logic         clr_done_b;

    int checks;
    int failures;
    int cnt;
    int done_cnt;

    regfile_mp_scoreboard dut (
        .clk(clk), .n_rst(n_rst),
        .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
        .wen(wen), .wsel(wsel), .wdat(wdat),
        .issue_en(issue_en), .issue_sel(issue_sel),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_mp_scoreboard #(
        .DATA_W(64), .NREGS(32), .NRD(4), .NWR(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .n_rst(n_rst),
        .rsel(rsel_b), .rdat(rdat_b), .rbusy(rbusy_b),
        .wen(wen_b), .wsel(wsel_b), .wdat(wdat_b),
        .issue_en(issue_en_b), .issue_sel(issue_sel_b),
        .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        n_rst = 1'b0;
        rsel = '0; wen = '0; wsel = '0; wdat = '0;
        issue_en = 1'b0; issue_sel = '0; clr_req = 1'b0;
        rsel_b = '0; wen_b = '0; wsel_b = '0; wdat_b = '0;
        issue_en_b = 1'b0; issue_sel_b = '0; clr_req_b = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rsel = {5'd5, 5'd9};
        #1;
        chk("rst_rdat", rdat, 64'h0);
        chk("rst_rbusy", 64'(rbusy), 64'h0);
        chk("rst_clr_busy", 64'(clr_busy), 64'h0);
        chk("rst_clr_done", 64'(clr_done), 64'h0);
        n_rst = 1'b1;
        tick();

        // 1: basic write/read and register 0
        wen = 2'b01; wsel[4:0] = 5'd5; wdat[31:0] = 32'hDEADBEEF;
        tick();
        wen = 2'b00; rsel[4:0] = 5'd5;
        #1;
        chk("rd_reg5", 64'(rdat[31:0]), 64'hDEADBEEF);
        wen = 2'b01; wsel[4:0] = 5'd0; wdat[31:0] = 32'h1234; rsel[4:0] = 5'd0;
        #1;
        chk("r0_bypass", 64'(rdat[31:0]), 64'h0);
        tick();
        wen = 2'b00;
        #1;
        chk("r0_stored", 64'(rdat[31:0]), 64'h0);
        chk("r0_busy", 64'(rbusy[0]), 64'h0);

        // 2: write-port conflict, highest index wins; bypass follows it
        wen = 2'b11; wsel = {5'd7, 5'd7}; wdat = {32'h2, 32'h1};
        rsel = {5'd7, 5'd5};
        #1;
        chk("conflict_bypass", 64'(rdat[63:32]), 64'h2);
        chk("other_port_rd5", 64'(rdat[31:0]), 64'hDEADBEEF);
        tick();
        wen = 2'b00;
        #1;
        chk("conflict_stored", 64'(rdat[63:32]), 64'h2);

        // 3: scoreboard
        wsel = '0; wdat = '0;
        issue_en = 1'b1; issue_sel = 5'd3;
        tick();
        issue_en = 1'b0; rsel = {5'd7, 5'd3};
        #1;
        chk("issue_busy", 64'(rbusy[0]), 64'h1);
        chk("other_not_busy", 64'(rbusy[1]), 64'h0);
        wen = 2'b01; wsel[4:0] = 5'd3; wdat[31:0] = 32'h55;
        #1;
        chk("wr_busy_bypass", 64'(rbusy[0]), 64'h0);
        chk("wr_data_bypass", 64'(rdat[31:0]), 64'h55);
        tick();
        wen = 2'b00;
        #1;
        chk("wr_busy_after", 64'(rbusy[0]), 64'h0);
        chk("wr_data_after", 64'(rdat[31:0]), 64'h55);
        wen = 2'b01; wsel[4:0] = 5'd3; wdat[31:0] = 32'h66;
        issue_en = 1'b1; issue_sel = 5'd3;
        tick();
        wen = 2'b00; issue_en = 1'b0;
        #1;
        chk("issue_beats_write", 64'(rbusy[0]), 64'h1);
        chk("issue_write_data", 64'(rdat[31:0]), 64'h66);

        // 4: fill, mark 9 pending, bulk clear
        for (int i = 1; i < 32; i++) begin
            wen = 2'b01; wsel[4:0] = 5'(i); wdat[31:0] = 32'(i);
            tick();
        end
        wen = 2'b00;
        issue_en = 1'b1; issue_sel = 5'd9;
        tick();
        issue_en = 1'b0; rsel = {5'd3, 5'd9};
        #1;
        chk("fill_rd9", 64'(rdat[31:0]), 64'h9);
        chk("fill_busy9", 64'(rbusy[0]), 64'h1);
        chk("fill_busy3", 64'(rbusy[1]), 64'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0; rsel[4:0] = 5'd4;
        wen = 2'b01; wsel[4:0] = 5'd4; wdat[31:0] = 32'hAAAA;
        issue_en = 1'b1; issue_sel = 5'd12;
        #1;
        chk("clr_no_bypass", 64'(rdat[31:0]), 64'h4);
        cnt = 0; done_cnt = 0;
        while (clr_busy === 1'b1 && cnt < 40) begin
            if (clr_done !== 1'b0) done_cnt++;
            cnt++;
            if (cnt == 8) begin
                wen = 2'b00;
                issue_en = 1'b0;
            end
            tick();
        end
        chk("clr_cycles", 64'(cnt), 64'd31);
        chk("clr_done_early", 64'(done_cnt), 64'h0);
        chk("clr_done_pulse", 64'(clr_done), 64'h1);
        tick();
        chk("clr_done_once", 64'(clr_done), 64'h0);
        for (int i = 0; i < 32; i++) begin
            rsel = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("clr_rd%0d", i), 64'(rdat[31:0]), 64'h0);
            chk($sformatf("clr_busy%0d", i), 64'(rbusy), 64'h0);
        end

        // 5: reset in the 10th clear cycle
        wen = 2'b01; wsel[4:0] = 5'd20; wdat[31:0] = 32'h77;
        tick();
        wen = 2'b00;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        chk("midclr_busy", 64'(clr_busy), 64'h1);
        n_rst = 1'b0;
        rsel = {5'd31, 5'd20};
        #1;
        chk("abort_busy", 64'(clr_busy), 64'h0);
        chk("abort_done", 64'(clr_done), 64'h0);
        chk("abort_rd20", 64'(rdat[31:0]), 64'h0);
        tick();
        n_rst = 1'b1;
        done_cnt = 0;
        repeat (4) begin
            tick();
            if (clr_done !== 1'b0) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'h0);
        wen = 2'b01; wsel[4:0] = 5'd6; wdat[31:0] = 32'hCAFE;
        tick();
        wen = 2'b00; rsel[4:0] = 5'd6;
        #1;
        chk("post_rst_write", 64'(rdat[31:0]), 64'hCAFE);

        // 6: wide, no-bypass instance
        wen_b = 1'b1; wsel_b = 5'd2; wdat_b = 64'h1111;
        tick();
        wdat_b = 64'h0123_4567_89AB_CDEF;
        rsel_b = {5'd2, 5'd2, 5'd2, 5'd2};
        #1;
        chk("nobyp_old", rdat_b[63:0], 64'h1111);
        tick();
        wen_b = 1'b0;
        #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("wide_rd_p%0d", p), rdat_b[p*64 +: 64], 64'h0123_4567_89AB_CDEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
